// File: rtl/cordic_pkg.sv
// cordic_pkg: shared sequencer state encoding, default iteration count and index-width helper
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int N_ITER_DEF = 6;

    // Narrowest index that can address every iteration, never less than one bit.
    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// cordic_seq_ctrl_if: command, comparator, datapath-control and result handshake bundle
//   master: drives start, gt, lt, res_ready; observes controller outputs
//   slave : the sequencer; drives busy, dp_load, dp_en, iter_idx, result, res_valid, cmp_err
interface cordic_seq_ctrl_if #(
    parameter int N_ITER = 6,
    parameter int IDX_W  = 3
);
    logic              start;
    logic              gt;
    logic              lt;
    logic              res_ready;
    logic              busy;
    logic              dp_load;
    logic              dp_en;
    logic [IDX_W-1:0]  iter_idx;
    logic [N_ITER-1:0] result;
    logic              res_valid;
    logic              cmp_err;

    modport master (
        output start, gt, lt, res_ready,
        input  busy, dp_load, dp_en, iter_idx, result, res_valid, cmp_err
    );

    modport slave (
        input  start, gt, lt, res_ready,
        output busy, dp_load, dp_en, iter_idx, result, res_valid, cmp_err
    );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: steps the CORDIC datapath through N_ITER iterations and collects the direction word
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : slave side of cordic_seq_ctrl_if (start/gt/lt/res_ready in; control and result out)
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER = N_ITER_DEF,
    parameter int IDX_W  = idx_w(N_ITER)
) (
    input  logic              CLK,
    input  logic              RST_N,
    cordic_seq_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_LOAD = LOAD;
    localparam logic [1:0] S_ITER = ITER;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_ITER-1:0] result_q, result_d;
    logic              err_q, err_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d  = S_LOAD;
                result_d = '0;
                err_d    = 1'b0;
            end
            S_LOAD: state_d = S_ITER;
            S_ITER: begin
                result_d[idx_q] = bus.gt;
                if (bus.gt && bus.lt) err_d = 1'b1;
                // Last iteration parks the index at 0 so it never exceeds N_ITER-1.
                if (idx_q == IDX_W'(N_ITER - 1)) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: if (bus.res_ready) begin
                state_d = bus.start ? S_LOAD : S_IDLE;
                if (bus.start) begin
                    result_d = '0;
                    err_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Control outputs decode from state only; no input reaches an output combinationally.
    assign bus.busy      = (state_q == S_LOAD) || (state_q == S_ITER);
    assign bus.dp_load   = state_q == S_LOAD;
    assign bus.dp_en     = state_q == S_ITER;
    assign bus.res_valid = state_q == S_DONE;
    assign bus.iter_idx  = idx_q;
    assign bus.result    = result_q;
    assign bus.cmp_err   = err_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb_cordic_seq_ctrl: directed and random operations checked against a bit-vector reference model
module tb_cordic_seq_ctrl;
    localparam int N  = 6;
    localparam int IW = 3;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int checks   = 0;
    int failures = 0;

    cordic_seq_ctrl_if #(.N_ITER(N), .IDX_W(IW)) bus ();

    cordic_seq_ctrl #(.N_ITER(N), .IDX_W(IW)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic busy, input logic ld, input logic en,
                           input logic [IW-1:0] idx, input logic [N-1:0] res,
                           input logic vld, input logic err);
        chk({tag, ".busy"},     bus.busy, busy);
        chk({tag, ".dp_load"},  bus.dp_load, ld);
        chk({tag, ".dp_en"},    bus.dp_en, en);
        chk({tag, ".iter_idx"}, bus.iter_idx, idx);
        chk({tag, ".result"},   bus.result, res);
        chk({tag, ".res_valid"}, bus.res_valid, vld);
        chk({tag, ".cmp_err"},  bus.cmp_err, err);
    endtask

    // Model: final result equals the gt vector; the error flag is any iteration with gt and lt both set.
    // During iteration k only the bits below k have been captured.
    task automatic do_op(input string tag, input logic [N-1:0] g, input logic [N-1:0] l,
                         input int hold, input bit b2b, input bit noise, input bit in_load);
        logic [N-1:0] mask;
        logic         exp_err;
        exp_err = |(g & l);
        if (!in_load) begin
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
        end
        chk_all({tag, ".load"}, 1, 1, 0, 0, '0, 0, 0);
        for (int k = 0; k < N; k++) begin
            step();
            mask = N'((1 << k) - 1);
            chk_all({tag, ".iter"}, 1, 0, 1, IW'(k), g & mask, 0, |(g & l & mask));
            bus.gt    = g[k];
            bus.lt    = l[k];
            bus.start = noise && (k == 3);
        end
        step();
        bus.gt = 1'b0;
        bus.lt = 1'b0;
        bus.start = 1'b0;
        chk_all({tag, ".done"}, 0, 0, 0, 0, g, 1, exp_err);
        for (int h = 0; h < hold; h++) begin
            bus.start = noise && (h == 1);
            bus.gt = 1'($urandom);
            bus.lt = 1'($urandom);
            step();
            chk_all({tag, ".hold"}, 0, 0, 0, 0, g, 1, exp_err);
        end
        bus.start = b2b;
        bus.res_ready = 1'b1;
        step();
        bus.start = 1'b0;
        bus.res_ready = 1'b0;
        bus.gt = 1'b0;
        bus.lt = 1'b0;
        if (b2b) chk_all({tag, ".b2b"}, 1, 1, 0, 0, '0, 0, 0);
        else     chk_all({tag, ".idle"}, 0, 0, 0, 0, g, 0, exp_err);
    endtask

    initial begin
        logic [N-1:0] g, l;
        bus.start = 1'b0;
        bus.gt = 1'b0;
        bus.lt = 1'b0;
        bus.res_ready = 1'b0;
        repeat (5) @(posedge CLK);
        #3;
        chk_all("reset", 0, 0, 0, 0, '0, 0, 0);
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.gt = 1'($urandom);
            bus.lt = 1'($urandom);
            bus.res_ready = 1'($urandom);
            step();
            chk_all("idle", 0, 0, 0, 0, '0, 0, 0);
        end
        bus.gt = 1'b0;
        bus.lt = 1'b0;
        bus.res_ready = 1'b0;

        do_op("basic", 6'h0D, 6'h32, 4, 1, 0, 0);
        do_op("all_gt", 6'h3F, 6'h00, 0, 0, 0, 1);
        chk("basic_const", 32'(bus.result), 32'h3F);
        do_op("eq_err", 6'h3B, 6'h10, 1, 0, 0, 0);
        do_op("clean", 6'h15, 6'h2A, 0, 0, 0, 0);
        do_op("ignore_start", 6'h2C, 6'h13, 3, 0, 1, 0);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) begin
            bus.gt = 1'b1;
            bus.lt = 1'b1;
            step();
        end
        chk("midrst.pre_idx", 32'(bus.iter_idx), 32'd2);
        #2;
        RST_N = 1'b0;
        #1;
        chk_all("midrst.async", 0, 0, 0, 0, '0, 0, 0);
        bus.gt = 1'b0;
        bus.lt = 1'b0;
        step();
        step();
        chk_all("midrst.held", 0, 0, 0, 0, '0, 0, 0);
        #3;
        RST_N = 1'b1;
        step();
        chk_all("midrst.after", 0, 0, 0, 0, '0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            g = N'($urandom);
            l = N'($urandom);
            do_op("rand", g, l, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 0);
            if (bus.busy) begin
                do_op("rand_b2b", N'($urandom), N'($urandom), 1, 0, 0, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
